// File: rtl/pauli_frame_tracker.sv
// Pauli frame tracker: filters single-qubit corrections through a two-round
// persistence check per axis, then toggles the tracked X/Z frame of that qubit.
module pauli_frame_tracker (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] correction,
   input  logic [1:0] axis,
   input  logic       clr,
   input  logic [2:0] qsel,
   output logic       frame_x,
   output logic       frame_z,
   output logic       applied,
   output logic [3:0] count,
   output logic       err
);

   typedef enum logic [1:0] {
      AX_IDLE = 2'b00,
      AX_X    = 2'b01,
      AX_Y    = 2'b10,
      AX_Z    = 2'b11
   } axis_t;

   axis_t      ax;
   logic [4:0] frame_x_r, frame_z_r, pend_x, pend_y, pend_z;
   logic [4:0] frame_x_n, frame_z_n, pend_x_n, pend_y_n, pend_z_n;
   logic [4:0] pend_sel, confirmed;
   logic [3:0] count_r, count_n;
   logic       err_r, err_n, applied_r, applied_n;
   logic       multi;

   assign ax = axis_t'(axis);

   always_comb begin
      frame_x_n = frame_x_r;
      frame_z_n = frame_z_r;
      pend_x_n  = pend_x;
      pend_y_n  = pend_y;
      pend_z_n  = pend_z;
      count_n   = count_r;
      err_n     = err_r;
      applied_n = 1'b0;
      confirmed = '0;
      pend_sel  = '0;
      multi     = (correction & (correction - 5'd1)) != 5'd0;

      case (ax)
         AX_X:    pend_sel = pend_x;
         AX_Y:    pend_sel = pend_y;
         AX_Z:    pend_sel = pend_z;
         default: pend_sel = '0;
      endcase

      if (ax != AX_IDLE) begin
         if (multi) begin
            err_n = 1'b1;
         end else begin
            // A confirmed bit is consumed so a third report starts a new pair.
            confirmed = correction & pend_sel;
            case (ax)
               AX_X: begin
                  pend_x_n  = correction & ~confirmed;
                  frame_x_n = frame_x_r ^ confirmed;
               end
               AX_Y: begin
                  pend_y_n  = correction & ~confirmed;
                  frame_x_n = frame_x_r ^ confirmed;
                  frame_z_n = frame_z_r ^ confirmed;
               end
               AX_Z: begin
                  pend_z_n  = correction & ~confirmed;
                  frame_z_n = frame_z_r ^ confirmed;
               end
               default: ;
            endcase
            applied_n = |confirmed;
            if ((|confirmed) && (count_r != 4'hF))
               count_n = count_r + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         frame_x_r <= '0;
         frame_z_r <= '0;
         pend_x    <= '0;
         pend_y    <= '0;
         pend_z    <= '0;
         count_r   <= '0;
         err_r     <= 1'b0;
         applied_r <= 1'b0;
      end else if (clr) begin
         frame_x_r <= '0;
         frame_z_r <= '0;
         pend_x    <= '0;
         pend_y    <= '0;
         pend_z    <= '0;
         count_r   <= '0;
         err_r     <= 1'b0;
         applied_r <= 1'b0;
      end else begin
         frame_x_r <= frame_x_n;
         frame_z_r <= frame_z_n;
         pend_x    <= pend_x_n;
         pend_y    <= pend_y_n;
         pend_z    <= pend_z_n;
         count_r   <= count_n;
         err_r     <= err_n;
         applied_r <= applied_n;
      end
   end

   // Qubit 0 lives in bit 4; out-of-range selects read as zero.
   always_comb begin
      frame_x = 1'b0;
      frame_z = 1'b0;
      case (qsel)
         3'd0: begin frame_x = frame_x_r[4]; frame_z = frame_z_r[4]; end
         3'd1: begin frame_x = frame_x_r[3]; frame_z = frame_z_r[3]; end
         3'd2: begin frame_x = frame_x_r[2]; frame_z = frame_z_r[2]; end
         3'd3: begin frame_x = frame_x_r[1]; frame_z = frame_z_r[1]; end
         3'd4: begin frame_x = frame_x_r[0]; frame_z = frame_z_r[0]; end
         default: ;
      endcase
   end

   assign applied = applied_r;
   assign count   = count_r;
   assign err     = err_r;

endmodule

// File: tb/tb_pauli_frame_tracker.sv
// Directed bench for pauli_frame_tracker with hand-computed expectations.
module tb_pauli_frame_tracker;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] correction;
   logic [1:0] axis;
   logic       clr;
   logic [2:0] qsel;
   logic       frame_x, frame_z, applied, err;
   logic [3:0] count;

   int checks = 0;
   int errors = 0;

   pauli_frame_tracker dut (
      .CLK        (CLK),
      .RST        (RST),
      .correction (correction),
      .axis       (axis),
      .clr        (clr),
      .qsel       (qsel),
      .frame_x    (frame_x),
      .frame_z    (frame_z),
      .applied    (applied),
      .count      (count),
      .err        (err)
   );

   always #5 CLK = ~CLK;

   task automatic step(input logic [4:0] c, input logic [1:0] a);
      correction = c;
      axis       = a;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic fx, input logic fz,
                      input logic ap, input logic er, input logic [3:0] cnt);
      logic [7:0] obs, exp;
      obs = {frame_x, frame_z, applied, err, count};
      exp = {fx, fz, ap, er, cnt};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed fx,fz,ap,err,cnt=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      RST = 1'b1; correction = '0; axis = 2'b00; clr = 1'b0; qsel = 3'd0;
      #3;
      chk("reset", 0, 0, 0, 0, 4'd0);
      #9;
      RST = 1'b0;

      // single X report then zero report: filtered out
      step(5'b10000, 2'b01);  chk("x_single_1", 0, 0, 0, 0, 4'd0);
      step(5'b00000, 2'b01);  chk("x_single_2", 0, 0, 0, 0, 4'd0);

      // X pair confirms, third report does not
      step(5'b10000, 2'b01);  chk("x_pair_1", 0, 0, 0, 0, 4'd0);
      step(5'b10000, 2'b01);  chk("x_pair_2", 1, 0, 1, 0, 4'd1);
      step(5'b10000, 2'b01);  chk("x_third", 1, 0, 0, 0, 4'd1);
      step(5'b00000, 2'b01);  chk("x_zero", 1, 0, 0, 0, 4'd1);

      // clr then Y pairs on qubit 2
      clr = 1'b1;
      step(5'b00000, 2'b00);  chk("clr_1", 0, 0, 0, 0, 4'd0);
      clr = 1'b0;
      qsel = 3'd2;
      step(5'b00100, 2'b10);  chk("y_pair_a1", 0, 0, 0, 0, 4'd0);
      step(5'b00100, 2'b10);  chk("y_pair_a2", 1, 1, 1, 0, 4'd1);
      step(5'b00100, 2'b10);  chk("y_pair_b1", 1, 1, 0, 0, 4'd1);
      step(5'b00100, 2'b10);  chk("y_pair_b2", 0, 0, 1, 0, 4'd2);

      // multi-bit correction flags err, sticky, no state change
      step(5'b01100, 2'b11);  chk("multi_err", 0, 0, 0, 1, 4'd2);
      step(5'b00000, 2'b11);  chk("err_sticky", 0, 0, 0, 1, 4'd2);
      qsel = 3'd1;            #1;
      chk("multi_q1", 0, 0, 0, 1, 4'd2);

      // err round between a Z pair leaves pending intact
      qsel = 3'd3;
      step(5'b00010, 2'b11);  chk("z_pend", 0, 0, 0, 1, 4'd2);
      step(5'b01100, 2'b11);  chk("z_err_mid", 0, 0, 0, 1, 4'd2);
      step(5'b00010, 2'b11);  chk("z_confirm", 0, 1, 1, 1, 4'd3);

      // idle round with data leaves pending intact
      qsel = 3'd4;
      step(5'b00001, 2'b11);  chk("idle_pend", 0, 0, 0, 1, 4'd3);
      step(5'b00001, 2'b00);  chk("idle_round", 0, 0, 0, 1, 4'd3);
      step(5'b00001, 2'b11);  chk("idle_confirm", 0, 1, 1, 1, 4'd4);

      // other-axis round leaves X pending intact
      qsel = 3'd0;
      step(5'b10000, 2'b01);  chk("xz_pend", 0, 0, 0, 1, 4'd4);
      step(5'b10000, 2'b11);  chk("xz_other", 0, 0, 0, 1, 4'd4);
      step(5'b10000, 2'b01);  chk("xz_confirm", 1, 0, 1, 1, 4'd5);

      qsel = 3'd5;            #1;
      chk("qsel5", 0, 0, 1, 1, 4'd5);
      qsel = 3'd7;            #1;
      chk("qsel7", 0, 0, 1, 1, 4'd5);

      // saturation over 20 confirmed X corrections on qubit 0
      qsel = 3'd0;
      clr = 1'b1;
      step(5'b00000, 2'b00);  chk("clr_2", 0, 0, 0, 0, 4'd0);
      clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(5'b10000, 2'b01);
         step(5'b10000, 2'b01);
         if (i == 13) chk("sat_14", 0, 0, 1, 0, 4'd14);
         if (i == 14) chk("sat_15", 1, 0, 1, 0, 4'd15);
      end
      chk("sat_20", 0, 0, 1, 0, 4'd15);

      // clr coincident with a confirming Y report
      qsel = 3'd2;
      step(5'b00100, 2'b10);  chk("clr_pend", 0, 0, 0, 0, 4'd15);
      clr = 1'b1;
      step(5'b00100, 2'b10);  chk("clr_override", 0, 0, 0, 0, 4'd0);
      clr = 1'b0;
      step(5'b00100, 2'b10);  chk("clr_no_pend", 0, 0, 0, 0, 4'd0);

      // async reset mid-cycle with nonzero frame, err and applied
      qsel = 3'd3;
      step(5'b11000, 2'b10);  chk("pre_rst_err", 0, 0, 0, 1, 4'd0);
      step(5'b00010, 2'b01);  chk("pre_rst_pend", 0, 0, 0, 1, 4'd0);
      step(5'b00010, 2'b11);  chk("pre_rst_z1", 0, 0, 0, 1, 4'd0);
      step(5'b00010, 2'b11);  chk("pre_rst_z2", 0, 1, 1, 1, 4'd1);
      #2;
      RST = 1'b1;
      #1;
      chk("async_rst", 0, 0, 0, 0, 4'd0);
      #1;
      RST = 1'b0;
      step(5'b00010, 2'b01);  chk("rst_drop_pend", 0, 0, 0, 0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pauli_frame_tracker.md
PAULI_FRAME_TRACKER -- requirements
Module: pauli_frame_tracker

Interface
REQ-001 SHALL have ports: CLK  input  1  rising-edge clock.
REQ-002 SHALL have ports: RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: correction  input  5  one-hot qubit correction from upstream syndrome decoder; bit 4 = qubit 0 … bit 0 = qubit 4.
REQ-004 SHALL have ports: axis  input  2  Pauli axis of correction: 00 idle, 01 X, 10 Y, 11 Z.
REQ-005 SHALL have ports: clr  input  1  synchronous clear of all tracker state.
REQ-006 SHALL have ports: qsel  input  3  qubit index for frame readout, 0..4.
REQ-007 SHALL have ports: frame_x  output  1  X component of Pauli frame for qubit qsel.
REQ-008 SHALL have ports: frame_z  output  1  Z component of Pauli frame for qubit qsel.
REQ-009 SHALL have ports: applied  output  1  one-cycle pulse: frame updated this edge.
REQ-010 SHALL have ports: count  output  4  saturating count of applied corrections.
REQ-011 SHALL have ports: err  output  1  sticky flag: non-one-hot, non-zero correction seen.

Function
REQ-012 SHALL hold state: frame_x_r[4:0], frame_z_r[4:0], pending registers pend_x, pend_y, pend_z (5 bits each), count_r, err_r, applied_r.
REQ-013 SHALL sample correction and axis on every rising CLK edge; all state updates occur at that edge (1-cycle latency, input to frame/applied/count).
REQ-014 SHALL treat axis=00 as idle: no frame, pending, count or err change; applied=0.
REQ-015 SHALL, for axis≠00 with correction zero or one-hot, compute confirmed = correction AND pend[axis] (persistence filter: same qubit, same axis, two consecutive rounds).
REQ-016 SHALL update pend[axis] <= correction AND NOT confirmed; pending registers of the other two axes unchanged.
REQ-017 SHALL toggle frame per confirmed bit: X -> frame_x_r ^= confirmed; Z -> frame_z_r ^= confirmed; Y -> both ^= confirmed.
REQ-018 SHALL set applied_r=1 for exactly one cycle when confirmed≠0, else 0.
REQ-019 SHALL increment count_r by 1 when confirmed≠0, saturating at 15 (no wrap).
REQ-020 SHALL, for axis≠00 with more than one correction bit set, set err_r=1, leave frame, pending and count unchanged, applied=0.
REQ-021 SHALL, when clr=1 at an edge, clear frame, all pending, count_r, err_r, applied_r to 0, overriding any simultaneous update.
REQ-022 SHALL drive frame_x/frame_z combinationally from frame registers indexed by qsel (qsel=0 -> bit 4, qsel=4 -> bit 0); qsel 5..7 -> both 0.
REQ-023 SHALL drive applied, count, err directly from registers (no combinational path from correction/axis).
REQ-024 SHALL not check axis ordering; any sequence of axis values is processed per REQ-014..020.

Reset
REQ-025 SHALL, while RST=1, asynchronously force frame_x_r, frame_z_r, pend_x/y/z, count_r, err_r, applied_r to 0, independent of CLK.
REQ-026 SHALL resume normal operation at the first rising edge after RST deasserts; reset mid-round discards all pending corrections.

Verification
REQ-027 SHALL verify: axis=01, correction=10000 for one round only (then zero corrections) -> applied stays 0, qsel=0 frame_x=0, count=0.
REQ-028 SHALL verify: axis=01, correction=10000 in two consecutive X slots -> applied pulses 1 cycle after second, qsel=0 frame_x=1, frame_z=0, count=1; third consecutive report -> no apply (pend cleared), count=1.
REQ-029 SHALL verify: axis=10, correction=00100 two consecutive Y slots -> qsel=2 frame_x=1, frame_z=1; repeat pair -> both return to 0, count=2.
REQ-030 SHALL verify: correction=01100 with axis=11 -> err=1 sticky, frame and count unchanged; correction=00000 any axis -> no change.
REQ-031 SHALL verify: 20 confirmed corrections -> count=15 (saturated); clr=1 coincident with a confirming update -> all outputs 0, no toggle.
REQ-032 SHALL verify: RST asserted between CLK edges with frame nonzero -> all outputs 0 immediately; pending report before reset plus one matching report after -> no apply.
